primitive_sr_bram_mtap: RTL and testbench
=========================================

# primitive_sr_bram_mtap

Parametrised, BRAM-backed logical shift register with two independent read taps, a write-hold mode, pointer resync and fill tracking. It is the general delay-line primitive for the operator/channel pipelines, where 32-slot time-multiplexed state is carried through long serial delays. It replaces flop chains wherever LENGTH × WIDTH is large. Outputs are zero-masked until valid data has reached each tap, so downstream logic never sees uninitialised RAM.

## Interface
Parameters:
- WIDTH, 1, data width in bits
- LENGTH, 32, logical stage count; 2 ≤ LENGTH ≤ 1024
- TAP_A, 32, tap A stage index; 2 ≤ TAP_A ≤ LENGTH
- TAP_B, 16, tap B stage index; 2 ≤ TAP_B ≤ LENGTH

Ports:
- i_EMUCLK  in  1  master clock; all state changes on posedge
- i_RST  in  1  asynchronous, active-high reset
- i_CEN_n  in  1  clock enable, active low; an "enabled edge" is a posedge with i_CEN_n = 0
- i_SYNC  in  1  pointer resync request
- i_WR  in  1  1 = write i_D into the current slot; 0 = keep old slot content (recirculate)
- i_D  in  WIDTH  input data
- o_Q_A  out  WIDTH  tap A data, registered
- o_Q_B  out  WIDTH  tap B data, registered
- o_PHASE  out  clog2(LENGTH)  current write pointer
- o_FULL  out  1  high once LENGTH enabled edges have occurred since reset

## Operation
- State:
  - write pointer `ptr`, range 0..LENGTH-1
  - fill counter `fill`, saturating at LENGTH
  - RAM `mem[LENGTH]`
  - output registers
- Equivalent model: after enabled edge n, o_Q_X equals the value written at enabled edge n-(TAP_X-1). This is the same result as stage TAP_X-1 of a flop chain.
- On each enabled edge, with `ptr` being the value before the edge:
  - Write: if i_WR = 1 or fill < LENGTH, then mem[ptr] <= i_D. During the first LENGTH edges, i_WR is ignored and treated as 1, so every slot is written once.
  - Read address: raddr_X = (ptr + LENGTH - (TAP_X-1)) mod LENGTH. Because TAP ≥ 2, raddr never equals ptr, so there is no read-during-write collision.
  - Tap output: o_Q_X <= (fill ≥ TAP_X-1) ? mem[raddr_X] : 0.
  - Pointer: ptr <= i_SYNC ? 0 : (ptr == LENGTH-1 ? 0 : ptr+1).
  - Fill: fill <= min(fill+1, LENGTH). i_SYNC does not affect fill.
- Non-enabled edges: all state holds.
- i_SYNC only relocates future writes. A tap stays consistent with the shift model only when SYNC coincides with a natural wrap (ptr == LENGTH-1). A SYNC at any other point corrupts tap data for the next LENGTH edges. This is required behaviour and is not to be compensated.
- o_PHASE = ptr.
- o_FULL = (fill == LENGTH).
- With i_WR = 0 (after fill), the slot keeps the value written LENGTH edges earlier. Tap outputs then present that old data TAP-1 edges later.

## Timing
- Reset (async assert, sync-free release): ptr = 0, fill = 0, o_Q_A = o_Q_B = 0, o_FULL = 0. RAM contents are not reset.
- Reset mid-operation: pointer and masking restart immediately. Old RAM data is unreachable until it has been rewritten, because of the fill mask and the forced writes.
- Latency: i_D sampled at edge k appears on o_Q_X after edge k+TAP_X-1 and holds until the next enabled edge.
- o_FULL rises after the LENGTH-th enabled edge and then stays high until reset.
- Tap masking lifts after the enabled edge on which fill == TAP_X-1 (pre-edge value).
- i_CEN_n high for any duration: no state change, and outputs hold.

## Structure
- A shared package holds a `clog2` function and a `sr_tap_addr` function (the modular address computation). These are reused by the other BRAM primitives.
- One sub-module, `primitive_sdpram`: simple dual-port RAM with one write port and two registered read ports. It is inferred BRAM with no reset. The parent holds ptr, fill, masking and SYNC.
- Elaboration-time assertions check the TAP and LENGTH ranges.

## Test plan
- Fill and latency. Setup: WIDTH=8, LENGTH=32, TAP_A=32, TAP_B=16. Apply reset, then i_D = n+1 on enabled edge n. Required:
  - o_Q_B = 0 through edge 14, and o_Q_B = 1 after edge 15.
  - o_Q_A = 1 after edge 31, and o_Q_A = n-30 thereafter.
  - o_FULL rises after edge 31.
- Hold mode. After fill, set i_WR = 0 for 32 edges. Required: o_Q_A repeats the previous 32-value sequence exactly, and o_Q_B is offset by 16.
- Forced write during fill. Same setup as the first scenario, but hold i_WR = 0 from reset. Required: taps still produce 1, 2, …, so i_WR is ignored until o_FULL.
- Clock enable. Toggle i_CEN_n with pattern 0,1,1,0,…. Required: the output sequence equals the fully enabled run, indexed by enabled edges only.
- SYNC. Required:
  - SYNC asserted at ptr = 31: o_PHASE goes 31→0 and tap data is unchanged.
  - SYNC asserted at ptr = 10: o_PHASE → 0 on the next edge, and o_FULL is unchanged.
- Async reset mid-run. Assert i_RST at ptr = 20, between clock edges. Required: o_Q_A, o_Q_B, o_PHASE and o_FULL go to 0 immediately, and the first scenario's fill behaviour repeats after release.

Source files
------------

// File: rtl/primitive_sr_bram_mtap_pkg.sv
// Shared helpers for the BRAM-backed delay-line primitives.
package primitive_sr_bram_mtap_pkg;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

    // Slot that held the sample written (tap-1) edges before the current slot.
    function automatic int sr_tap_addr(input int ptr, input int length, input int tap);
        return (ptr + length - (tap - 1)) % length;
    endfunction

endpackage

// File: rtl/primitive_sdpram.sv
// Simple dual-port RAM: one write port and two registered read ports.
// Neither the array nor the read registers are reset, so the RAM infers as block RAM.
module primitive_sdpram #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr_a,
    input  logic [AW-1:0]    i_raddr_b,
    output logic [WIDTH-1:0] o_rdata_a,
    output logic [WIDTH-1:0] o_rdata_b
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_a_q;
    logic [WIDTH-1:0] rdata_b_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            rdata_a_q <= mem[i_raddr_a];
            rdata_b_q <= mem[i_raddr_b];
        end
    end

    assign o_rdata_a = rdata_a_q;
    assign o_rdata_b = rdata_b_q;

endmodule

// File: rtl/primitive_sr_bram_mtap.sv
// Logical shift register held in BRAM with two fixed read taps, write-hold,
// pointer resync and fill tracking; taps read zero until real data reaches them.
module primitive_sr_bram_mtap
    import primitive_sr_bram_mtap_pkg::*;
#(
    parameter  int WIDTH  = 1,
    parameter  int LENGTH = 32,
    parameter  int TAP_A  = 32,
    parameter  int TAP_B  = 16,
    localparam int PTR_W  = clog2(LENGTH)
) (
    input  logic             i_EMUCLK,
    input  logic             i_RST,
    input  logic             i_CEN_n,
    input  logic             i_SYNC,
    input  logic             i_WR,
    input  logic [WIDTH-1:0] i_D,
    output logic [WIDTH-1:0] o_Q_A,
    output logic [WIDTH-1:0] o_Q_B,
    output logic [PTR_W-1:0] o_PHASE,
    output logic             o_FULL
);

    localparam int FILL_W = clog2(LENGTH + 1);

    if (LENGTH < 2 || LENGTH > 1024) begin : g_bad_length
        $error("primitive_sr_bram_mtap: LENGTH must be within 2..1024");
    end
    if (TAP_A < 2 || TAP_A > LENGTH) begin : g_bad_tap_a
        $error("primitive_sr_bram_mtap: TAP_A must be within 2..LENGTH");
    end
    if (TAP_B < 2 || TAP_B > LENGTH) begin : g_bad_tap_b
        $error("primitive_sr_bram_mtap: TAP_B must be within 2..LENGTH");
    end

    logic [PTR_W-1:0]  ptr_q,   ptr_d;
    logic [FILL_W-1:0] fill_q,  fill_d;
    logic              vld_a_q, vld_a_d;
    logic              vld_b_q, vld_b_d;
    logic              en;
    logic              full;
    logic              wr_en;
    logic [PTR_W-1:0]  raddr_a;
    logic [PTR_W-1:0]  raddr_b;
    logic [WIDTH-1:0]  rdata_a;
    logic [WIDTH-1:0]  rdata_b;

    always_comb begin
        en      = ~i_CEN_n;
        full    = (fill_q == FILL_W'(LENGTH));
        // Until every slot has been written once, writes are forced so stale RAM never surfaces.
        wr_en   = en & (i_WR | ~full);
        raddr_a = PTR_W'(sr_tap_addr(int'(ptr_q), LENGTH, TAP_A));
        raddr_b = PTR_W'(sr_tap_addr(int'(ptr_q), LENGTH, TAP_B));

        ptr_d   = ptr_q;
        fill_d  = fill_q;
        vld_a_d = vld_a_q;
        vld_b_d = vld_b_q;

        if (en) begin
            if (i_SYNC || (ptr_q == PTR_W'(LENGTH - 1))) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
            if (!full) begin
                fill_d = fill_q + 1'b1;
            end
            vld_a_d = (fill_q >= FILL_W'(TAP_A - 1));
            vld_b_d = (fill_q >= FILL_W'(TAP_B - 1));
        end
    end

    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            ptr_q   <= '0;
            fill_q  <= '0;
            vld_a_q <= 1'b0;
            vld_b_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            fill_q  <= fill_d;
            vld_a_q <= vld_a_d;
            vld_b_q <= vld_b_d;
        end
    end

    primitive_sdpram #(
        .WIDTH (WIDTH),
        .DEPTH (LENGTH),
        .AW    (PTR_W)
    ) u_ram (
        .i_clk     (i_EMUCLK),
        .i_we      (wr_en),
        .i_waddr   (ptr_q),
        .i_wdata   (i_D),
        .i_re      (en),
        .i_raddr_a (raddr_a),
        .i_raddr_b (raddr_b),
        .o_rdata_a (rdata_a),
        .o_rdata_b (rdata_b)
    );

    // The RAM read registers carry no reset; the valid flags gate them so reset clears the taps at once.
    assign o_Q_A   = vld_a_q ? rdata_a : '0;
    assign o_Q_B   = vld_b_q ? rdata_b : '0;
    assign o_PHASE = ptr_q;
    assign o_FULL  = full;

endmodule

// File: tb/tb_primitive_sr_bram_mtap.sv
// Directed bench for primitive_sr_bram_mtap against a delay-line reference model.
module tb_primitive_sr_bram_mtap;

    localparam int W  = 8;
    localparam int L  = 32;
    localparam int TA = 32;
    localparam int TB = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         cen_n;
    logic         sync;
    logic         wr;
    logic [W-1:0] d;
    logic [W-1:0] q_a;
    logic [W-1:0] q_b;
    logic [4:0]   phase;
    logic         full;

    int checks   = 0;
    int failures = 0;

    // Reference: value entering the delay line on each enabled edge since reset.
    int hist[$];
    int n_en;
    int ptr_m;
    bit tap_ok;
    bit chk_en = 1'b0;

    primitive_sr_bram_mtap #(
        .WIDTH  (W),
        .LENGTH (L),
        .TAP_A  (TA),
        .TAP_B  (TB)
    ) dut (
        .i_EMUCLK (clk),
        .i_RST    (rst),
        .i_CEN_n  (cen_n),
        .i_SYNC   (sync),
        .i_WR     (wr),
        .i_D      (d),
        .o_Q_A    (q_a),
        .o_Q_B    (q_b),
        .o_PHASE  (phase),
        .o_FULL   (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        n_en   = 0;
        ptr_m  = 0;
        tap_ok = 1'b1;
    endtask

    // Drive one cycle, advance the model on the edge, return just after the next falling edge.
    task automatic step(input bit c_n, input bit w, input bit s, input int dv);
        cen_n = c_n;
        wr    = w;
        sync  = s;
        d     = W'(dv);
        @(posedge clk);
        if (!c_n) begin
            int e;
            if (w || n_en < L) e = dv & 255;
            else               e = hist[n_en - L];
            hist.push_back(e);
            if (s && ptr_m != L - 1) tap_ok = 1'b0;
            ptr_m = s ? 0 : (ptr_m + 1) % L;
            n_en  = n_en + 1;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic fill_run(input bit w, input string tag);
        for (int n = 0; n < 40; n++) begin
            step(1'b0, w, 1'b0, n + 1);
            if (n == 14) chk({tag, "_qb_masked_e14"}, int'(q_b), 0);
            if (n == 15) chk({tag, "_qb_first_e15"}, int'(q_b), 1);
            if (n == 30) begin
                chk({tag, "_full_low_e30"}, int'(full), 0);
                chk({tag, "_qa_masked_e30"}, int'(q_a), 0);
            end
            if (n == 31) begin
                chk({tag, "_full_high_e31"}, int'(full), 1);
                chk({tag, "_qa_first_e31"}, int'(q_a), 1);
            end
            if (n == 39) begin
                chk({tag, "_qa_e39"}, int'(q_a), 9);
                chk({tag, "_qb_e39"}, int'(q_b), 25);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic advance_to(input int target);
        for (int i = 0; i < 64 && ptr_m != target; i++) begin
            step(1'b0, 1'b1, 1'b0, n_en + 1);
        end
        chk("reach_ptr", int'(phase), target);
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("phase", int'(phase), ptr_m);
            chk("full", int'(full), (n_en >= L) ? 1 : 0);
            if (tap_ok) begin
                chk("tap_a", int'(q_a), (n_en >= TA) ? hist[n_en - TA] : 0);
                chk("tap_b", int'(q_b), (n_en >= TB) ? hist[n_en - TB] : 0);
            end
        end
    end

    initial begin
        int f_before;
        rst   = 1'b1;
        cen_n = 1'b1;
        sync  = 1'b0;
        wr    = 1'b1;
        d     = '0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_qa", int'(q_a), 0);
        chk("rst_qb", int'(q_b), 0);
        chk("rst_phase", int'(phase), 0);
        chk("rst_full", int'(full), 0);
        rst    = 1'b0;
        chk_en = 1'b1;

        fill_run(1'b1, "fill");

        // Hold: each slot recirculates what was written one lap earlier.
        for (int n = 40; n < 72; n++) begin
            step(1'b0, 1'b0, 1'b0, int'($urandom_range(0, 255)));
        end
        chk("hold_qa_e71", int'(q_a), 9);
        chk("hold_qb_e71", int'(q_b), 25);

        do_reset();
        fill_run(1'b0, "forced");

        do_reset();
        for (int i = 0; i < 64; i++) begin
            bit c;
            c = (i % 4 == 1) || (i % 4 == 2);
            step(c, 1'b1, 1'b0, n_en + 1);
            if (!c && n_en == 15) chk("cen_qb_masked", int'(q_b), 0);
            if (!c && n_en == 16) chk("cen_qb_first", int'(q_b), 1);
            if (!c && n_en == 32) chk("cen_qa_first", int'(q_a), 1);
        end

        advance_to(31);
        step(1'b0, 1'b1, 1'b1, n_en + 1);
        chk("sync_wrap_phase", int'(phase), 0);
        chk("sync_wrap_qa", int'(q_a), n_en - 31);
        step(1'b0, 1'b1, 1'b0, n_en + 1);
        chk("sync_wrap_qa_next", int'(q_a), n_en - 31);
        chk("sync_wrap_qb_next", int'(q_b), n_en - 15);

        advance_to(10);
        f_before = int'(full);
        step(1'b0, 1'b1, 1'b1, n_en + 1);
        chk("sync_mid_phase", int'(phase), 0);
        chk("sync_mid_full", int'(full), f_before);

        advance_to(20);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_qa", int'(q_a), 0);
        chk("async_rst_qb", int'(q_b), 0);
        chk("async_rst_phase", int'(phase), 0);
        chk("async_rst_full", int'(full), 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        fill_run(1'b1, "refill");

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
